// File: rtl/cache_perf_monitor.sv
// Cache performance monitor: per-channel access/miss counters,
// a run-cycle counter and sticky saturation flags under a start/stop FSM.
module cache_perf_monitor #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16,
  parameter int CYC_W  = 20,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic [NUM_CH-1:0] proc_req,
  input  logic [NUM_CH-1:0] proc_stall,
  input  logic [NUM_CH-1:0] mem_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_acc,
  output logic [CNT_W-1:0]  rd_miss,
  output logic [CYC_W-1:0]  cycles,
  output logic [NUM_CH-1:0] sat,
  output logic [1:0]        state
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  logic [NUM_CH-1:0][CNT_W-1:0] acc_q;
  logic [NUM_CH-1:0][CNT_W-1:0] miss_q;
  logic [NUM_CH-1:0]            mem_req_d;
  logic [NUM_CH-1:0]            acc_ev;
  logic [NUM_CH-1:0]            miss_ev;
  logic [CNT_W-1:0]             acc_sel;
  logic [CNT_W-1:0]             miss_sel;
  logic                         run;

  assign run     = (state == RUN);
  assign acc_ev  = proc_req & ~proc_stall;
  assign miss_ev = mem_req & ~mem_req_d;

  // Window FSM; clear beats stop beats start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else if (stop && state == RUN) begin
      state <= DONE;
    end else if (start && state == IDLE) begin
      state <= RUN;
    end
  end

  // Edge detector history, tracked in every state so a request
  // already high when the window opens is not seen as a new miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_d <= '0;
    end else if (clear) begin
      mem_req_d <= '0;
    end else begin
      mem_req_d <= mem_req;
    end
  end

  // Saturating access/miss counters with sticky overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      miss_q <= '0;
      sat    <= '0;
    end else if (clear) begin
      acc_q  <= '0;
      miss_q <= '0;
      sat    <= '0;
    end else if (run) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc_ev[i]) begin
          if (acc_q[i] == CNT_MAX) sat[i] <= 1'b1;
          else acc_q[i] <= acc_q[i] + CNT_W'(1);
        end
        if (miss_ev[i]) begin
          if (miss_q[i] == CNT_MAX) sat[i] <= 1'b1;
          else miss_q[i] <= miss_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Run-cycle counter; holds at all-ones without flagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles <= '0;
    end else if (clear) begin
      cycles <= '0;
    end else if (run && cycles != CYC_MAX) begin
      cycles <= cycles + CYC_W'(1);
    end
  end

  // Readout select; out-of-range channels read as zero.
  always_comb begin
    acc_sel  = '0;
    miss_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        acc_sel  = acc_q[i];
        miss_sel = miss_q[i];
      end
    end
  end

  // Registered readout, one cycle behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_acc  <= '0;
      rd_miss <= '0;
    end else begin
      rd_acc  <= acc_sel;
      rd_miss <= miss_sel;
    end
  end

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Scoreboard bench for cache_perf_monitor (CNT_W=4, CYC_W=5).
// Stimulus queues expected outputs; a negedge monitor checks them.
module tb_cache_perf_monitor;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] proc_req = '0;
  logic [2:0] proc_stall = '0;
  logic [2:0] mem_req = '0;
  logic [1:0] rd_sel = '0;
  logic [3:0] rd_acc;
  logic [3:0] rd_miss;
  logic [4:0] cycles;
  logic [2:0] sat;
  logic [1:0] state;

  typedef struct packed {
    logic [3:0] acc;
    logic [3:0] miss;
    logic [4:0] cyc;
    logic [2:0] sat;
    logic [1:0] st;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  cache_perf_monitor #(
    .NUM_CH(3), .CNT_W(4), .CYC_W(5), .SEL_W(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .stop(stop), .clear(clear),
    .proc_req(proc_req), .proc_stall(proc_stall),
    .mem_req(mem_req), .rd_sel(rd_sel),
    .rd_acc(rd_acc), .rd_miss(rd_miss),
    .cycles(cycles), .sat(sat), .state(state)
  );

  always #5 clk = ~clk;

  // Monitor: compare queued expectations at the falling edge.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {rd_acc, rd_miss, cycles, sat, state};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got acc=%0d miss=%0d cyc=%0d sat=%b st=%b, want acc=%0d miss=%0d cyc=%0d sat=%b st=%b",
                 nm, a.acc, a.miss, a.cyc, a.sat, a.st,
                 e.acc, e.miss, e.cyc, e.sat, e.st);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic s, input logic p, input logic c,
                     input logic [2:0] rq, input logic [2:0] sl,
                     input logic [2:0] mr);
    start = s;
    stop = p;
    clear = c;
    proc_req = rq;
    proc_stall = sl;
    mem_req = mr;
  endtask

  task automatic chk(input string nm, input int a, input int m,
                     input int c, input int s, input logic [1:0] st);
    exp_t e;
    e.acc = 4'(a);
    e.miss = 4'(m);
    e.cyc = 5'(c);
    e.sat = 3'(s);
    e.st = st;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic mp[8];
    mp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset
    tick();
    tick();
    chk("reset", 0, 0, 0, 0, IDLE);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Stalled accesses on ch1
    rd_sel = 2'd1;
    drv(1, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0, 3'b010, (i == 1 || i == 3) ? 3'b010 : 3'b000, 0);
      tick();
    end
    drv(0, 1, 0, 0, 0, 0); tick();
    chk("acc_stall", 3, 0, 6, 0, DONE);
    drv(1, 0, 0, 3'b010, 0, 0); tick();
    chk("done_hold", 3, 0, 6, 0, DONE);

    // Clear, readout lag, stop ignored in IDLE
    drv(0, 0, 1, 0, 0, 0); tick();
    chk("clear_lag", 3, 0, 0, 0, IDLE);
    drv(0, 0, 0, 0, 0, 0); tick();
    chk("clear_zero", 0, 0, 0, 0, IDLE);
    drv(0, 1, 0, 0, 0, 0); tick();
    chk("stop_idle", 0, 0, 0, 0, IDLE);

    // Miss edges on ch0, ch2 held high across start
    rd_sel = 2'd0;
    drv(0, 0, 0, 0, 0, 3'b100); tick();
    drv(1, 0, 0, 0, 0, 3'b100); tick();
    for (int i = 0; i < 8; i++) begin
      drv(0, 0, 0, 0, 0, {2'b10, mp[i]});
      tick();
    end
    drv(0, 1, 0, 0, 0, 3'b100); tick();
    chk("miss_ch0", 0, 2, 9, 0, DONE);
    rd_sel = 2'd2;
    tick();
    chk("miss_ch2", 0, 0, 9, 0, DONE);
    drv(0, 0, 1, 0, 0, 0); tick();
    chk("clear2", 0, 0, 0, 0, IDLE);

    // Access counter saturation on ch2
    drv(1, 0, 0, 0, 0, 0); tick();
    for (int i = 1; i <= 17; i++) begin
      drv(0, 0, 0, 3'b100, 0, 0);
      tick();
      if (i == 15) chk("sat_edge", 14, 0, 15, 0, RUN);
      if (i == 16) chk("sat_set", 15, 0, 16, 4, RUN);
      if (i == 17) chk("sat_run", 15, 0, 17, 4, RUN);
    end
    drv(0, 1, 0, 0, 0, 0); tick();
    chk("sat_hold", 15, 0, 18, 4, DONE);
    drv(0, 0, 1, 0, 0, 0); tick();
    chk("sat_clear", 15, 0, 0, 0, IDLE);
    drv(0, 0, 0, 0, 0, 0); tick();
    chk("sat_clear2", 0, 0, 0, 0, IDLE);

    // Cycle counter saturation
    drv(1, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0);
    repeat (35) tick();
    chk("cyc_sat", 0, 0, 31, 0, RUN);
    drv(0, 1, 0, 0, 0, 0); tick();
    chk("cyc_done", 0, 0, 31, 0, DONE);
    drv(0, 0, 1, 0, 0, 0); tick();
    chk("cyc_clear", 0, 0, 0, 0, IDLE);

    // clear+stop+start together with an access event
    rd_sel = 2'd0;
    drv(1, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 3'b001, 0, 0); tick();
    drv(1, 1, 1, 3'b001, 0, 3'b001); tick();
    chk("all_ctrl", 1, 0, 0, 0, IDLE);
    drv(0, 0, 0, 0, 0, 0); tick();
    chk("all_ctrl2", 0, 0, 0, 0, IDLE);

    // Out-of-range select, then async reset mid-RUN
    rd_sel = 2'd3;
    drv(1, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 3'b111, 0, 3'b111); tick();
    tick();
    chk("sel_oob", 0, 0, 2, 0, RUN);
    rd_sel = 2'd0;
    tick();
    chk("sel0_run", 2, 1, 3, 0, RUN);
    tick();
    rst_n = 1'b0;
    chk("rst_async", 0, 0, 0, 0, IDLE);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    rd_sel = 2'd3;
    tick();
    chk("post_rst_oob", 0, 0, 0, 0, IDLE);
    rd_sel = 2'd0;
    tick();
    tick();
    chk("post_rst_idle", 0, 0, 0, 0, IDLE);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
